// File: rtl/code_lock_seq_param.sv
// rtl/code_lock_seq_param.sv - sequence-code lock with timed OK/ERR and failure lockout (optional CODE_LOCK_PROG_EN)
module code_lock_seq_param #(
    parameter int                             ENTRY_W     = 8,
    parameter int                             N_ENTRIES   = 3,
    parameter logic [N_ENTRIES*ENTRY_W-1:0]   CODE        = 24'hFF00FF,
    parameter int                             MAX_FAIL    = 3,
    parameter int                             SHOW_CYC    = 25000000,
    parameter int                             LOCKOUT_CYC = 0,
    localparam int                            IDX_W       = $clog2(N_ENTRIES + 1),
    localparam int                            FAIL_W      = $clog2(MAX_FAIL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_pulse,
    input  logic [ENTRY_W-1:0] code_in,
    input  logic               clr,
`ifdef CODE_LOCK_PROG_EN
    input  logic               prog_req,
`endif
    output logic               ok,
    output logic               err,
    output logic               locked,
    output logic [IDX_W-1:0]   entry_idx,
    output logic [FAIL_W-1:0]  fail_cnt
);

    localparam int CAP_W     = N_ENTRIES * ENTRY_W;
    localparam int DWELL_MAX = (SHOW_CYC > LOCKOUT_CYC) ? SHOW_CYC : LOCKOUT_CYC;
    localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

    localparam logic [DWELL_W-1:0] SHOW_LAST = DWELL_W'(SHOW_CYC - 1);
    localparam logic [DWELL_W-1:0] LOCK_LAST = DWELL_W'((LOCKOUT_CYC > 0) ? (LOCKOUT_CYC - 1) : 0);
    localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(DWELL_MAX);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_ENTRIES - 1);
    localparam logic [IDX_W-1:0]   IDX_FULL  = IDX_W'(N_ENTRIES);
    localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAIL);

`ifdef CODE_LOCK_PROG_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_SHOW_OK, S_SHOW_ERR, S_LOCKOUT, S_PROG, S_PROG_ACK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_SHOW_OK, S_SHOW_ERR, S_LOCKOUT
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CAP_W-1:0]    cap_q, cap_d, cap_wr;
    logic [IDX_W-1:0]    entry_idx_q, entry_idx_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;
    logic                locked_q, locked_d;
    logic [CAP_W-1:0]    code_ref;

`ifdef CODE_LOCK_PROG_EN
    logic [CAP_W-1:0]    code_q, code_d;
    assign code_ref = code_q;
`else
    assign code_ref = CODE;
`endif

    // Capture word with the current slot replaced by the incoming switch word
    always_comb begin
        cap_wr = cap_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (entry_idx_q == IDX_W'(i)) begin
                cap_wr[i*ENTRY_W +: ENTRY_W] = code_in;
            end
        end
    end

    // Next-state and registered-output logic of the lock sequencer
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        entry_idx_d = entry_idx_q;
        fail_cnt_d  = fail_cnt_q;
        ok_d        = ok_q;
        err_d       = err_q;
        locked_d    = locked_q;
`ifdef CODE_LOCK_PROG_EN
        code_d      = code_q;
`endif
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (clr) begin
                    // clr aborts an entry in progress; in IDLE it only swallows a same-cycle pulse
                    if (state_q == S_ENTRY) begin
                        entry_idx_d = '0;
                        state_d     = S_IDLE;
                    end
                end else if (btn_pulse) begin
                    cap_d = cap_wr;
                    if (entry_idx_q == IDX_LAST) begin
                        entry_idx_d = IDX_FULL;
                        state_d     = S_CHECK;
                    end else begin
                        entry_idx_d = entry_idx_q + IDX_W'(1);
                        state_d     = S_ENTRY;
                    end
                end
            end
            S_CHECK: begin
                if (cap_q == code_ref) begin
                    state_d    = S_SHOW_OK;
                    ok_d       = 1'b1;
                    fail_cnt_d = '0;
                end else begin
                    state_d = S_SHOW_ERR;
                    err_d   = 1'b1;
                    if (fail_cnt_q != FAIL_MAX) begin
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                    end
                end
            end
            S_SHOW_OK: begin
                if (dwell_q == SHOW_LAST) begin
                    state_d     = S_IDLE;
                    ok_d        = 1'b0;
                    entry_idx_d = '0;
`ifdef CODE_LOCK_PROG_EN
                    if (prog_req) begin
                        state_d = S_PROG;
                        ok_d    = 1'b1;
                    end
`endif
                end
            end
            S_SHOW_ERR: begin
                if (dwell_q == SHOW_LAST) begin
                    err_d       = 1'b0;
                    entry_idx_d = '0;
                    if (fail_cnt_q == FAIL_MAX) begin
                        state_d  = S_LOCKOUT;
                        locked_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                // With LOCKOUT_CYC == 0 only rst leaves this state
                if ((LOCKOUT_CYC != 0) && (dwell_q == LOCK_LAST)) begin
                    state_d    = S_IDLE;
                    locked_d   = 1'b0;
                    fail_cnt_d = '0;
                end
            end
`ifdef CODE_LOCK_PROG_EN
            S_PROG: begin
                if (clr) begin
                    state_d     = S_IDLE;
                    ok_d        = 1'b0;
                    entry_idx_d = '0;
                end else if (btn_pulse) begin
                    cap_d = cap_wr;
                    if (entry_idx_q == IDX_LAST) begin
                        code_d      = cap_wr;
                        err_d       = 1'b1;
                        entry_idx_d = IDX_FULL;
                        state_d     = S_PROG_ACK;
                    end else begin
                        entry_idx_d = entry_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PROG_ACK: begin
                state_d     = S_IDLE;
                ok_d        = 1'b0;
                err_d       = 1'b0;
                entry_idx_d = '0;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shared dwell counter: restarts on every state change and saturates instead of wrapping
    always_comb begin
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end else begin
            dwell_d = dwell_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            entry_idx_q <= '0;
            fail_cnt_q  <= '0;
            dwell_q     <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
            code_q      <= CODE;
`endif
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            entry_idx_q <= entry_idx_d;
            fail_cnt_q  <= fail_cnt_d;
            dwell_q     <= dwell_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
`ifdef CODE_LOCK_PROG_EN
            code_q      <= code_d;
`endif
        end
    end

    assign ok        = ok_q;
    assign err       = err_q;
    assign locked    = locked_q;
    assign entry_idx = entry_idx_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_code_lock_seq_param.sv
// tb/tb_code_lock_seq_param.sv - randomized self-checking bench for code_lock_seq_param (optional CODE_LOCK_PROG_EN)
module tb_code_lock_seq_param;

    localparam int          SHOW     = 4;
    localparam int          LOCK     = 8;
    localparam int          MAXF     = 3;
    localparam logic [23:0] CODE_DEF = 24'hFF00FF;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pulse;
    logic       clr;
    logic [7:0] code_in;
`ifdef CODE_LOCK_PROG_EN
    logic       prog_req;
`endif

    logic       ok, err, locked;
    logic [1:0] entry_idx, fail_cnt;
    logic       ok0, err0, locked0;
    logic [1:0] entry_idx0, fail_cnt0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_fail   = 0;
    logic [23:0] m_code   = CODE_DEF;

    always #5 clk = ~clk;

    code_lock_seq_param #(.SHOW_CYC(SHOW), .LOCKOUT_CYC(LOCK)) dut (
        .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .code_in(code_in), .clr(clr),
`ifdef CODE_LOCK_PROG_EN
        .prog_req(prog_req),
`endif
        .ok(ok), .err(err), .locked(locked), .entry_idx(entry_idx), .fail_cnt(fail_cnt)
    );

    code_lock_seq_param #(.SHOW_CYC(SHOW), .LOCKOUT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .code_in(code_in), .clr(clr),
`ifdef CODE_LOCK_PROG_EN
        .prog_req(prog_req),
`endif
        .ok(ok0), .err(err0), .locked(locked0), .entry_idx(entry_idx0), .fail_cnt(fail_cnt0)
    );

    task automatic pulse(input logic [7:0] w);
        btn_pulse = 1'b1;
        code_in   = w;
        @(negedge clk);
        btn_pulse = 1'b0;
        code_in   = 8'($urandom);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic enter_word(input logic [23:0] w, input int max_gap);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            pulse(w[i*8 +: 8]);
        end
    endtask

    // Enters one attempt and checks the whole OK/ERR/lockout episode against the attempt-level model
    task automatic run_attempt(input logic [23:0] w, input string tag);
        logic exp_match;
        enter_word(w, 2);
        exp_match = (w == m_code);
        n_checks++;
        if (entry_idx !== 2'd3 || ok !== 1'b0 || err !== 1'b0)
            $display("FAIL %s check_cycle: idx=%0d ok=%0b err=%0b required idx=3 ok=0 err=0", tag, entry_idx, ok, err);
        else n_pass++;
        for (int k = 1; k <= SHOW; k++) begin
            @(negedge clk);
            n_checks++;
            if (ok !== exp_match || err !== !exp_match)
                $display("FAIL %s show_%0d: ok=%0b err=%0b required ok=%0b err=%0b", tag, k, ok, err, exp_match, !exp_match);
            else n_pass++;
        end
        m_fail = exp_match ? 0 : ((m_fail < MAXF) ? m_fail + 1 : MAXF);
        n_checks++;
        if (fail_cnt !== 2'(m_fail))
            $display("FAIL %s fail_cnt: got %0d required %0d", tag, fail_cnt, m_fail);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b0 || err !== 1'b0 || entry_idx !== 2'd0)
            $display("FAIL %s show_end: ok=%0b err=%0b idx=%0d required 0 0 0", tag, ok, err, entry_idx);
        else n_pass++;
        if (m_fail == MAXF) begin
            for (int k = 0; k < LOCK; k++) begin
                n_checks++;
                if (locked !== 1'b1 || ok !== 1'b0 || err !== 1'b0 || entry_idx !== 2'd0 || fail_cnt !== 2'(MAXF))
                    $display("FAIL %s lockout_%0d: locked=%0b ok=%0b err=%0b idx=%0d fail=%0d required 1 0 0 0 %0d",
                             tag, k, locked, ok, err, entry_idx, fail_cnt, MAXF);
                else n_pass++;
                btn_pulse = 1'($urandom_range(1, 0));
                code_in   = 8'($urandom);
                @(negedge clk);
            end
            btn_pulse = 1'b0;
            m_fail = 0;
            n_checks++;
            if (locked !== 1'b0 || fail_cnt !== 2'd0 || entry_idx !== 2'd0)
                $display("FAIL %s lockout_end: locked=%0b fail=%0d idx=%0d required 0 0 0", tag, locked, fail_cnt, entry_idx);
            else n_pass++;
        end else begin
            n_checks++;
            if (locked !== 1'b0)
                $display("FAIL %s not_locked: locked=%0b required 0", tag, locked);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_pulse = 1'b0; clr = 1'b0; code_in = 8'h00;
`ifdef CODE_LOCK_PROG_EN
        prog_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ok, err, locked, entry_idx, fail_cnt} !== 7'd0)
            $display("FAIL reset_dut: ok=%0b err=%0b locked=%0b idx=%0d fail=%0d required all 0", ok, err, locked, entry_idx, fail_cnt);
        else n_pass++;
        n_checks++;
        if ({ok0, err0, locked0, entry_idx0, fail_cnt0} !== 7'd0)
            $display("FAIL reset_dut0: ok=%0b err=%0b locked=%0b idx=%0d fail=%0d required all 0", ok0, err0, locked0, entry_idx0, fail_cnt0);
        else n_pass++;
        rst = 1'b0;
        m_fail = 0;
        m_code = CODE_DEF;
    endtask

    task automatic test_basic();
        run_attempt(CODE_DEF, "correct");
        run_attempt(24'hFF01FF, "wrong");
    endtask

    task automatic test_lockout_timed();
        run_attempt(24'h123456, "wrong2");
        run_attempt(24'h00FF00, "wrong3");
        run_attempt(CODE_DEF, "after_lockout");
    endtask

    task automatic test_clr();
        pulse(8'hFF);
        n_checks++;
        if (entry_idx !== 2'd1) $display("FAIL clr_idx1: got %0d required 1", entry_idx); else n_pass++;
        pulse(8'h00);
        n_checks++;
        if (entry_idx !== 2'd2) $display("FAIL clr_idx2: got %0d required 2", entry_idx); else n_pass++;
        do_clr();
        n_checks++;
        if (entry_idx !== 2'd0 || fail_cnt !== 2'(m_fail) || ok !== 1'b0 || err !== 1'b0)
            $display("FAIL clr_abort: idx=%0d fail=%0d ok=%0b err=%0b required 0 %0d 0 0", entry_idx, fail_cnt, ok, err, m_fail);
        else n_pass++;
        run_attempt(CODE_DEF, "after_clr");
        btn_pulse = 1'b1; clr = 1'b1; code_in = 8'hFF;
        @(negedge clk);
        btn_pulse = 1'b0; clr = 1'b0;
        n_checks++;
        if (entry_idx !== 2'd0) $display("FAIL clr_btn_idle: idx=%0d required 0", entry_idx); else n_pass++;
        pulse(8'hFF);
        btn_pulse = 1'b1; clr = 1'b1; code_in = 8'h00;
        @(negedge clk);
        btn_pulse = 1'b0; clr = 1'b0;
        n_checks++;
        if (entry_idx !== 2'd0) $display("FAIL clr_btn_entry: idx=%0d required 0", entry_idx); else n_pass++;
        run_attempt(CODE_DEF, "after_clr_btn");
    endtask

    task automatic test_random();
        logic [23:0] w;
        int          slot;
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                pulse(8'($urandom));
                do_clr();
                n_checks++;
                if (entry_idx !== 2'd0) $display("FAIL rand_abort_%0d: idx=%0d required 0", n, entry_idx); else n_pass++;
            end
            case ($urandom_range(2, 0))
                0: w = m_code;
                1: begin
                    w = m_code;
                    slot = $urandom_range(2, 0);
                    w[slot*8 +: 8] = w[slot*8 +: 8] ^ 8'($urandom_range(255, 1));
                end
                default: w = 24'($urandom);
            endcase
            run_attempt(w, "random");
        end
    endtask

    task automatic test_lockout_perm();
        int held;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_fail = 0;
        run_attempt(24'h010203, "perm1");
        run_attempt(24'h040506, "perm2");
        run_attempt(24'h070809, "perm3");
        held = 0;
        for (int k = 0; k < 1000; k++) begin
            if (locked0 === 1'b1 && ok0 === 1'b0 && err0 === 1'b0) held++;
            btn_pulse = 1'($urandom_range(1, 0));
            code_in   = 8'($urandom);
            @(negedge clk);
        end
        btn_pulse = 1'b0;
        n_checks++;
        if (held !== 1000) $display("FAIL perm_locked: held %0d cycles required 1000", held); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_fail = 0;
        n_checks++;
        if ({ok0, err0, locked0, entry_idx0, fail_cnt0} !== 7'd0)
            $display("FAIL perm_reset: ok=%0b err=%0b locked=%0b idx=%0d fail=%0d required all 0", ok0, err0, locked0, entry_idx0, fail_cnt0);
        else n_pass++;
    endtask

`ifdef CODE_LOCK_PROG_EN
    task automatic test_prog();
        enter_word(m_code, 1);
        for (int k = 1; k <= SHOW; k++) begin
            @(negedge clk);
            if (k == SHOW) prog_req = 1'b1;
        end
        @(negedge clk);
        prog_req = 1'b0;
        m_fail = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || err !== 1'b0) $display("FAIL prog_hold: ok=%0b err=%0b required 1 0", ok, err); else n_pass++;
        pulse(8'h12);
        pulse(8'h34);
        pulse(8'h56);
        n_checks++;
        if (ok !== 1'b1 || err !== 1'b1) $display("FAIL prog_ack: ok=%0b err=%0b required 1 1", ok, err); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b0 || err !== 1'b0 || entry_idx !== 2'd0)
            $display("FAIL prog_done: ok=%0b err=%0b idx=%0d required 0 0 0", ok, err, entry_idx);
        else n_pass++;
        m_code = 24'h563412;
        run_attempt(24'h563412, "new_code");
        run_attempt(CODE_DEF, "old_code");
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_lockout_timed();
        test_clr();
        test_random();
`ifdef CODE_LOCK_PROG_EN
        test_prog();
`endif
        test_lockout_perm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
